// File: rtl/seq_divider_unit.sv
// Radix-2 restoring integer divider: WORD_WIDTH-bit quotient/remainder, optional
// two's-complement mode, divide-by-zero flag. One operation in flight at a time.
// Latency: accept edge T -> out_valid after edge T+WORD_WIDTH+1 (T+1 for a zero divisor).
// Backpressure: in_ready only in IDLE; result held in OUTPUT until out_ready.
// Ports: clk/reset_n (async active-low), in_valid/in_ready + signed_mode/left_op/right_op
// operand side, out_valid/out_ready + quot/mod/div_by_zero result side, busy = not IDLE.
module seq_divider_unit #(
  parameter int WORD_WIDTH = 8,
  parameter bit SIGNED_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  signed_mode,
  input  logic [WORD_WIDTH-1:0] left_op,
  input  logic [WORD_WIDTH-1:0] right_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] quot,
  output logic [WORD_WIDTH-1:0] mod,
  output logic                  div_by_zero,
  output logic                  busy
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, OUTPUT} state_t;

  state_t        state_q;
  logic [W:0]    rem_q;        // partial remainder
  logic [W-1:0]  dvd_q;        // dividend bits shift out of the top, quotient bits shift in
  logic [W-1:0]  dvs_q;        // divisor magnitude
  logic [CW-1:0] cnt_q;
  logic          negq_q;       // operand signs differ
  logic          negr_q;       // dividend negative
  logic          dbz_pend_q;   // zero divisor: skip CALC, FIXUP writes the fixed result
  logic [W-1:0]  quot_q;
  logic [W-1:0]  mod_q;
  logic          out_valid_q;
  logic          dbz_q;

  // Operand preparation at accept
  logic          mode_eff;
  logic          l_neg;
  logic          r_neg;
  logic [W-1:0]  l_mag;
  logic [W-1:0]  r_mag;

  // One restoring step
  logic [W+1:0]  rem_wide;
  logic [W:0]    rem_diff;
  logic          qbit;
  logic [W:0]    rem_d;
  logic [W-1:0]  dvd_d;

  always_comb begin
    mode_eff = signed_mode & SIGNED_EN;
    l_neg    = mode_eff & left_op[W-1];
    r_neg    = mode_eff & right_op[W-1];
    l_mag    = l_neg ? -left_op  : left_op;
    r_mag    = r_neg ? -right_op : right_op;

    rem_wide = {rem_q, dvd_q[W-1]};
    qbit     = (rem_wide >= {2'b00, dvs_q});
    rem_diff = rem_wide[W:0] - {1'b0, dvs_q};
    rem_d    = qbit ? rem_diff : rem_wide[W:0];
    dvd_d    = {dvd_q[W-2:0], qbit};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      dbz_pend_q  <= 1'b0;
      quot_q      <= '0;
      mod_q       <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvs_q  <= r_mag;
            rem_q  <= '0;
            cnt_q  <= '0;
            negq_q <= l_neg ^ r_neg;
            negr_q <= l_neg;
            if (right_op == '0) begin
              // Keep the raw dividend: it is returned unmodified as the remainder.
              dvd_q      <= left_op;
              dbz_pend_q <= 1'b1;
              state_q    <= FIXUP;
            end else begin
              dvd_q      <= l_mag;
              dbz_pend_q <= 1'b0;
              state_q    <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_q <= FIXUP;
        end
        FIXUP: begin
          if (dbz_pend_q) begin
            quot_q <= '1;
            mod_q  <= dvd_q;
            dbz_q  <= 1'b1;
          end else begin
            // Truncating division: remainder follows the dividend's sign.
            // MIN / -1 wraps back to MIN through the unsigned magnitude.
            quot_q <= negq_q ? -dvd_q : dvd_q;
            mod_q  <= negr_q ? -rem_q[W-1:0] : rem_q[W-1:0];
          end
          out_valid_q <= 1'b1;
          state_q     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign quot        = quot_q;
  assign mod         = mod_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_unit.sv
// Bench for seq_divider_unit: three instances (8-bit signed-capable, 8-bit unsigned-only,
// 16-bit) share one operand bus; each result is checked against an integer-arithmetic model.
module tb_seq_divider_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid;
  logic        signed_mode;
  logic        out_ready;
  logic [15:0] a_i;
  logic [15:0] b_i;

  logic [7:0]  q8, m8, qu, mu;
  logic [15:0] q16, m16;
  logic        ir [3];
  logic        ov [3];
  logic        dz [3];
  logic        bz [3];
  logic [15:0] qo [3];
  logic [15:0] mo [3];

  assign qo[0] = {8'h00, q8};
  assign mo[0] = {8'h00, m8};
  assign qo[1] = {8'h00, qu};
  assign mo[1] = {8'h00, mu};
  assign qo[2] = q16;
  assign mo[2] = m16;

  int checks = 0;
  int passed = 0;

  seq_divider_unit #(.WORD_WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
    .signed_mode(signed_mode), .left_op(a_i[7:0]), .right_op(b_i[7:0]),
    .out_valid(ov[0]), .out_ready(out_ready), .quot(q8), .mod(m8),
    .div_by_zero(dz[0]), .busy(bz[0]));

  seq_divider_unit #(.WORD_WIDTH(8), .SIGNED_EN(1'b0)) dutu (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
    .signed_mode(signed_mode), .left_op(a_i[7:0]), .right_op(b_i[7:0]),
    .out_valid(ov[1]), .out_ready(out_ready), .quot(qu), .mod(mu),
    .div_by_zero(dz[1]), .busy(bz[1]));

  seq_divider_unit #(.WORD_WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]),
    .signed_mode(signed_mode), .left_op(a_i), .right_op(b_i),
    .out_valid(ov[2]), .out_ready(out_ready), .quot(q16), .mod(m16),
    .div_by_zero(dz[2]), .busy(bz[2]));

  function automatic int wid(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic logic [15:0] msk(input int i);
    return (i == 2) ? 16'hFFFF : 16'h00FF;
  endfunction

  // Reference: plain integer division with C-style truncation.
  function automatic void ref_div(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input bit sm, output logic [15:0] q, output logic [15:0] r);
    longint m, ua, ub, sa, sb;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    if (ub == 0) begin
      q = 16'(m);
      r = 16'(ua);
    end else if (sm) begin
      sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
      sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
      q  = 16'((sa / sb) & m);
      r  = 16'((sa % sb) & m);
    end else begin
      q = 16'(ua / ub);
      r = 16'(ua % ub);
    end
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit sm, input string tag);
    logic [15:0] eq [3];
    logic [15:0] er [3];
    int lat [3];
    bit seen [3];
    bit hs_bad [3];
    bit zd [3];
    for (int i = 0; i < 3; i++) begin
      ref_div(wid(i), a, b, (i == 1) ? 1'b0 : sm, eq[i], er[i]);
      zd[i]     = ((b & msk(i)) == 16'h0000);
      lat[i]    = zd[i] ? 1 : wid(i) + 1;
      seen[i]   = 1'b0;
      hs_bad[i] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (!(ir[0] && ir[1] && ir[2]))
      $display("FAIL %s in_ready before accept: got %b%b%b want 111", tag, ir[0], ir[1], ir[2]);
    else passed++;
    in_valid = 1'b1; a_i = a; b_i = b; signed_mode = sm; out_ready = 1'b1;
    @(negedge clk);
    // Accept edge has passed; scramble inputs to show latched operands are kept.
    in_valid = 1'b0; a_i = 16'($urandom); b_i = 16'($urandom); signed_mode = ~sm;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!seen[i]) begin
          if (ov[i] === 1'b1) begin
            seen[i] = 1'b1;
            checks++;
            if (k != lat[i]) $display("FAIL %s dut%0d latency: got %0d want %0d", tag, i, k, lat[i]);
            else passed++;
            checks++;
            if (qo[i] !== eq[i]) $display("FAIL %s dut%0d quot: got %h want %h", tag, i, qo[i], eq[i]);
            else passed++;
            checks++;
            if (mo[i] !== er[i]) $display("FAIL %s dut%0d mod: got %h want %h", tag, i, mo[i], er[i]);
            else passed++;
            checks++;
            if (dz[i] !== zd[i]) $display("FAIL %s dut%0d div_by_zero: got %b want %b", tag, i, dz[i], zd[i]);
            else passed++;
            checks++;
            if (hs_bad[i]) $display("FAIL %s dut%0d busy/in_ready while working: got bad want busy=1 in_ready=0", tag, i);
            else passed++;
          end else if (ir[i] !== 1'b0 || bz[i] !== 1'b1) begin
            hs_bad[i] = 1'b1;
          end
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
    end
    for (int i = 0; i < 3; i++) begin
      if (!seen[i]) begin
        checks++;
        $display("FAIL %s dut%0d timeout: got no out_valid want out_valid within 40 cycles", tag, i);
      end
    end
    @(negedge clk);
    checks++;
    if (!(ir[0] && ir[1] && ir[2]) || ov[0] || ov[1] || ov[2] || dz[0] || dz[1] || dz[2])
      $display("FAIL %s after retire: got ir=%b%b%b ov=%b%b%b dz=%b%b%b want ir=111 ov=000 dz=000",
               tag, ir[0], ir[1], ir[2], ov[0], ov[1], ov[2], dz[0], dz[1], dz[2]);
    else passed++;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (qo[i] !== 16'h0 || mo[i] !== 16'h0 || ov[i] !== 1'b0 || dz[i] !== 1'b0 || bz[i] !== 1'b0)
        $display("FAIL reset dut%0d: got q=%h m=%h ov=%b dz=%b busy=%b want all 0",
                 i, qo[i], mo[i], ov[i], dz[i], bz[i]);
      else passed++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (!(ir[0] && ir[1] && ir[2]))
      $display("FAIL reset in_ready: got %b%b%b want 111", ir[0], ir[1], ir[2]);
    else passed++;
  endtask

  task automatic test_unsigned;
    run_op(16'd200, 16'd7, 1'b0, "u_200_7");
    run_op(16'h0080, 16'h00FF, 1'b0, "u_80_ff");
  endtask

  task automatic test_signed;
    run_op(16'hFF9C, 16'd7, 1'b1, "s_m100_7");
    run_op(16'd100, 16'hFFF9, 1'b1, "s_100_m7");
    run_op(16'hFF9C, 16'hFFF9, 1'b1, "s_m100_m7");
    run_op(16'hFF80, 16'hFFFF, 1'b1, "s_min_m1");
  endtask

  task automatic test_div_zero;
    run_op(16'd55, 16'd0, 1'b0, "z_u");
    run_op(16'd55, 16'd0, 1'b1, "z_s");
    run_op(16'hFF9C, 16'd0, 1'b1, "z_neg");
    run_op(16'd55, 16'h0100, 1'b0, "z_low_byte");
  endtask

  task automatic test_wide;
    run_op(16'hFFFF, 16'h00FF, 1'b0, "w_65535_255");
  endtask

  task automatic test_backpressure;
    logic [15:0] eq [3];
    logic [15:0] er [3];
    bit ok;
    for (int i = 0; i < 3; i++) ref_div(wid(i), 16'd1000, 16'd3, 1'b0, eq[i], er[i]);
    @(negedge clk);
    in_valid = 1'b1; a_i = 16'd1000; b_i = 16'd3; signed_mode = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ov[0] && ov[1] && ov[2]) break;
      @(negedge clk);
    end
    checks++;
    if (!(ov[0] && ov[1] && ov[2]))
      $display("FAIL bp wait: got ov=%b%b%b want 111", ov[0], ov[1], ov[2]);
    else passed++;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        ok = (qo[i] === eq[i]) && (mo[i] === er[i]) && (ov[i] === 1'b1) &&
             (ir[i] === 1'b0) && (dz[i] === 1'b0);
        checks++;
        if (!ok)
          $display("FAIL bp hold c%0d dut%0d: got q=%h m=%h ov=%b ir=%b dz=%b want q=%h m=%h ov=1 ir=0 dz=0",
                   c, i, qo[i], mo[i], ov[i], ir[i], dz[i], eq[i], er[i]);
        else passed++;
      end
      if (c < 5) begin
        in_valid = (c % 2 == 0); a_i = 16'($urandom); b_i = 16'($urandom);
        signed_mode = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (!(ir[0] && ir[1] && ir[2]) || ov[0] || ov[1] || ov[2])
      $display("FAIL bp retire: got ir=%b%b%b ov=%b%b%b want ir=111 ov=000",
               ir[0], ir[1], ir[2], ov[0], ov[1], ov[2]);
    else passed++;
    run_op(16'd77, 16'd5, 1'b0, "bp_next");
  endtask

  task automatic test_reset_mid;
    run_op(16'd200, 16'd7, 1'b0, "pre_reset");
    @(negedge clk);
    in_valid = 1'b1; a_i = 16'd200; b_i = 16'd7; signed_mode = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (qo[i] !== 16'h0 || mo[i] !== 16'h0 || ov[i] !== 1'b0 || dz[i] !== 1'b0 || bz[i] !== 1'b0)
        $display("FAIL mid_reset dut%0d: got q=%h m=%h ov=%b dz=%b busy=%b want all 0",
                 i, qo[i], mo[i], ov[i], dz[i], bz[i]);
      else passed++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(16'd9, 16'd3, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'h0000;
        1: b = 16'($urandom_range(1, 15));
        2: b = {8'($urandom), 8'($urandom_range(1, 255))};
        default: b = 16'($urandom);
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b0;
    a_i = 16'h0; b_i = 16'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_wide();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
